rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
- Upstream stage of the 8-to-3 one-hot encoder.
- Captures pulsed request lines from 8 sources into a pending register.
- Picks one pending source by round-robin and presents it as a strictly one-hot grant vector with a valid/ready handshake.
- The grant vector drives the encoder input directly. The encoder only ever sees one-hot values, or all-zero when idle.

Parameters:
- N, 8, number of request sources; must be a power of two ≥2; 8 to match the encoder input width.
- PTR_W, 3, width of the round-robin pointer; equals log2(N).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request pulses, one bit per source; any number of bits may be high in one cycle.
- grant  output  N  one-hot grant, or all-zero when grant_valid=0; feeds the encoder input.
- grant_valid  output  1  grant holds a valid winner.
- grant_ready  input  1  downstream accepts the current grant.
- pending  output  N  captured, not-yet-granted requests (status).
- drop  output  1  sticky flag: a request was lost because its bit was already pending.

Behaviour:
- Reset (asynchronous, active-high), all state cleared:
  - pending=0, grant=0, grant_valid=0, drop=0, pointer=0, FSM=IDLE.
  - Reset asserted mid-offer aborts the offer immediately. The pending grant is lost and not replayed.
- Pending update, every edge:
  - pending <= (pending & ~clr) | req.
  - clr is the current grant when grant_valid & grant_ready, else 0.
  - A req bit equal to the bit being cleared in the same cycle keeps that bit set. This counts as a fresh request, not a drop.
- Drop:
  - Set when any bit satisfies req & pending & ~clr.
  - Stays set until reset.
- FSM, two states:
  - IDLE:
    - If pending≠0, select the first set bit of pending scanning circularly from pointer upward, wrapping N-1→0.
    - Load grant with that one-hot bit, set grant_valid=1, go to OFFER.
    - If pending=0, stay in IDLE with grant=0.
  - OFFER:
    - grant and grant_valid are held stable while grant_ready=0. No re-arbitration, even if new requests arrive.
    - On grant_ready=1: the winner's pending bit is cleared per the rule above; pointer <= (winner index + 1) mod N; grant <= 0; grant_valid <= 0; go to IDLE.
- Latency and throughput:
  - req high in cycle k → pending bit visible in cycle k+1 → grant_valid in cycle k+2 (if idle).
  - Maximum throughput is one grant every 2 cycles when grant_ready is held high.
- Fairness:
  - With all 8 bits continuously re-requested, grants rotate 0,1,…,7,0.
  - No source waits more than N grants.
- Invariants:
  - grant is always one-hot or zero, never multi-hot.
  - grant≠0 if and only if grant_valid=1.
- Pointer arithmetic:
  - Pointer is PTR_W bits unsigned; the increment wraps naturally.
- grant_ready while in IDLE is ignored.

Decomposition:
- Shared package holds:
  - constants N=8 and PTR_W=3;
  - FSM state encoding (IDLE=1'b0, OFFER=1'b1).
- One sub-module, rr_pick: purely combinational circular first-one finder.
  - Inputs: pending, pointer.
  - Outputs: one-hot winner, winner index, any.
  - Implementation: double-width mask-and-priority trick.
- The top level holds the pending register, FSM, pointer and drop flag.

Test Plan:
- Reset then single request: rst pulse; req=8'b0000_0100 for 1 cycle, grant_ready=1.
  - Required: grant=8'b0000_0100 with grant_valid=1 exactly 2 cycles after req.
  - The bit then clears from pending; grant returns to 0 the next cycle.
- Round-robin wrap: pointer at 0; req=8'b1000_0001 held for 1 cycle; grant_ready=1.
  - Required grant order: 8'b0000_0001, then 8'b1000_0000.
  - Next, req=8'b0000_0011 yields 8'b0000_0001 first: after index 7 the pointer wraps to 0.
- Backpressure hold: req=8'b0001_0000; grant_ready=0 for 5 cycles; during the stall inject req=8'b0000_0010.
  - Required: grant stays 8'b0001_0000 and grant_valid stays 1 for all 5 cycles.
  - After grant_ready=1, the next grant is 8'b0000_0010.
- Drop flag: req=8'b0000_1000 for 1 cycle, then again while still pending with grant_ready=0.
  - Required: drop=1 and stays 1.
  - Only one grant of 8'b0000_1000 is produced.
- Same-cycle re-request: bit 5 being consumed (grant_valid=1, grant_ready=1) while req=8'b0010_0000 in the same cycle.
  - Required: pending[5] remains 1 and drop stays 0.
  - Bit 5 is granted again after the other pending sources.
- Reset mid-offer: grant=8'b0100_0000 valid, assert rst asynchronously between edges.
  - Required: grant=0, grant_valid=0, pending=0, drop=0 immediately.
  - After release, the first grant of req=8'b1111_1111 is 8'b0000_0001.

Source files
------------

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin one-hot arbiter
// that feeds the 8-to-3 one-hot encoder.
package rr_onehot_arbiter_pkg;

    localparam int N     = 8;
    localparam int PTR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_onehot_arbiter_pick.sv
// Combinational circular first-one finder: the lowest set bit of pending at or
// above ptr, wrapping from N-1 back to 0.
module rr_pick
    import rr_onehot_arbiter_pkg::*;
(
    input  logic [N-1:0]     pending,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);

    logic [N-1:0]   one_s;
    logic [N-1:0]   mask_s;
    logic [2*N-1:0] dbl_s;
    logic [2*N-1:0] low_s;

    // Upper copy of pending is unmasked so the lowest set bit found in it is the wrapped winner.
    always_comb begin
        one_s   = {{(N-1){1'b0}}, 1'b1};
        mask_s  = ~((one_s << ptr) - one_s);
        dbl_s   = {pending, pending & mask_s};
        low_s   = dbl_s & (~dbl_s + {{(2*N-1){1'b0}}, 1'b1});
        winner  = low_s[N-1:0] | low_s[2*N-1:N];
        any     = |pending;
        win_idx = {PTR_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            win_idx = win_idx | (winner[i] ? PTR_W'(i) : {PTR_W{1'b0}});
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: captures request pulses into a pending register and
// offers one pending source at a time as a strictly one-hot grant.
module rr_onehot_arbiter
    import rr_onehot_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic [N-1:0] pending,
    output logic         drop
);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic             drop_q, drop_d;

    logic [N-1:0]     clr_s;
    logic [N-1:0]     pick_winner_s;
    logic [PTR_W-1:0] pick_idx_s;
    logic             pick_any_s;

    rr_pick u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .winner  (pick_winner_s),
        .win_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // A request landing on the bit being consumed this cycle is a fresh request, not a drop.
    always_comb begin
        clr_s     = (state_q == OFFER && grant_ready) ? grant_q : {N{1'b0}};
        pending_d = (pending_q & ~clr_s) | req;
        drop_d    = drop_q | (|(req & pending_q & ~clr_s));
    end

    // FSM next-state: arbitrate only from IDLE, hold the offer stable until accepted.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    grant_d       = pick_winner_s;
                    grant_valid_d = 1'b1;
                    idx_d         = pick_idx_s;
                    state_d       = OFFER;
                end else begin
                    grant_d       = {N{1'b0}};
                    grant_valid_d = 1'b0;
                end
            end
            OFFER: begin
                if (grant_ready) begin
                    ptr_d         = idx_q + {{(PTR_W-1){1'b0}}, 1'b1};
                    grant_d       = {N{1'b0}};
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    state_d       = OFFER;
                end
            end
            default: begin
                grant_d       = {N{1'b0}};
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= {N{1'b0}};
            grant_q       <= {N{1'b0}};
            grant_valid_q <= 1'b0;
            ptr_q         <= {PTR_W{1'b0}};
            idx_q         <= {PTR_W{1'b0}};
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            drop_q        <= drop_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign pending     = pending_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed and randomized checks of rr_onehot_arbiter against a behavioural
// reference model of the pending set, round-robin pointer and offer state.
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       grant_ready = 1'b0;
    logic [7:0] grant;
    logic       grant_valid;
    logic [7:0] pending;
    logic       drop;

    int n_tests = 0;
    int n_fail  = 0;
    int acc08   = 0;

    // Reference model state
    logic [7:0] m_pend = 8'h00;
    int         m_ptr  = 0;
    bit         m_off  = 1'b0;
    int         m_win  = 0;
    bit         m_drop = 1'b0;

    rr_onehot_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .pending     (pending),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_grant();
        logic [7:0] g;
        g = 8'h00;
        if (m_off) g[m_win] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_pend = 8'h00; m_ptr = 0; m_off = 1'b0; m_win = 0; m_drop = 1'b0;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".grant"},   grant, m_grant());
        chk({tag, ".valid"},   {7'd0, grant_valid}, {7'd0, m_off});
        chk({tag, ".pending"}, pending, m_pend);
        chk({tag, ".drop"},    {7'd0, drop}, {7'd0, m_drop});
        chk({tag, ".onehot0"}, {7'd0, $onehot0(grant)}, 8'h01);
        chk({tag, ".valid_iff_grant"}, {7'd0, (grant != 8'h00)}, {7'd0, grant_valid});
    endtask

    // One clock: drive inputs, advance the model by the stated rules, compare.
    task automatic step(input logic [7:0] r, input logic rdy, input string tag);
        logic [7:0] old_pend;
        logic [7:0] clr;
        bit         found;
        req = r;
        grant_ready = rdy;
        if (grant_valid && rdy && grant == 8'h08) acc08++;
        @(posedge clk);
        old_pend = m_pend;
        clr = (m_off && rdy) ? m_grant() : 8'h00;
        if ((r & old_pend & ~clr) != 8'h00) m_drop = 1'b1;
        m_pend = (old_pend & ~clr) | r;
        if (!m_off) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && old_pend[(m_ptr + k) % 8]) begin
                    m_win = (m_ptr + k) % 8;
                    m_off = 1'b1;
                    found = 1'b1;
                end
            end
        end else if (rdy) begin
            m_ptr = (m_win + 1) % 8;
            m_off = 1'b0;
        end
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        req = 8'h00;
        grant_ready = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_model("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input logic [7:0] exp, input logic rdy, input string tag);
        for (int i = 0; i < 8 && !grant_valid; i++) step(8'h00, rdy, tag);
        chk({tag, ".timeout"}, {7'd0, grant_valid}, 8'h01);
        chk(tag, grant, exp);
    endtask

    initial begin
        int ng;
        logic [7:0] r;
        logic       rdy;

        // Reset then single request: grant two cycles after req
        do_reset();
        step(8'b0000_0100, 1'b1, "single_req");
        chk("single_pending", pending, 8'b0000_0100);
        chk("single_not_yet", grant, 8'h00);
        step(8'h00, 1'b1, "single_k2");
        chk("single_grant_k2", grant, 8'b0000_0100);
        chk("single_valid_k2", {7'd0, grant_valid}, 8'h01);
        step(8'h00, 1'b1, "single_done");
        chk("single_cleared", grant, 8'h00);
        chk("single_pend_clr", pending, 8'h00);

        // Round-robin wrap from pointer 0
        do_reset();
        step(8'b1000_0001, 1'b1, "wrap_req");
        wait_grant(8'b0000_0001, 1'b1, "wrap_first");
        step(8'h00, 1'b1, "wrap_acc1");
        wait_grant(8'b1000_0000, 1'b1, "wrap_second");
        step(8'h00, 1'b1, "wrap_acc2");
        step(8'b0000_0011, 1'b1, "wrap_req2");
        wait_grant(8'b0000_0001, 1'b1, "wrap_after7");
        step(8'h00, 1'b1, "wrap_acc3");
        wait_grant(8'b0000_0010, 1'b1, "wrap_fourth");
        step(8'h00, 1'b1, "wrap_acc4");

        // Backpressure hold with a new request arriving during the stall
        do_reset();
        step(8'b0001_0000, 1'b0, "bp_req");
        step(8'h00, 1'b0, "bp_offer");
        for (int i = 0; i < 5; i++) begin
            step((i == 2) ? 8'b0000_0010 : 8'h00, 1'b0, "bp_stall");
            chk("bp_hold_grant", grant, 8'b0001_0000);
            chk("bp_hold_valid", {7'd0, grant_valid}, 8'h01);
        end
        step(8'h00, 1'b1, "bp_accept");
        wait_grant(8'b0000_0010, 1'b1, "bp_next");
        step(8'h00, 1'b1, "bp_acc2");

        // Drop flag: repeat request while still pending
        do_reset();
        acc08 = 0;
        step(8'b0000_1000, 1'b0, "drop_req1");
        step(8'b0000_1000, 1'b0, "drop_req2");
        chk("drop_set", {7'd0, drop}, 8'h01);
        for (int i = 0; i < 6; i++) step(8'h00, 1'b1, "drop_drain");
        chk("drop_sticky", {7'd0, drop}, 8'h01);
        chk("drop_one_grant", 8'(acc08), 8'd1);

        // Same-cycle re-request of the bit being consumed
        do_reset();
        step(8'b0110_0000, 1'b0, "same_req");
        step(8'h00, 1'b0, "same_offer");
        chk("same_first", grant, 8'b0010_0000);
        step(8'b0010_0000, 1'b1, "same_consume");
        chk("same_pend5", {7'd0, pending[5]}, 8'h01);
        chk("same_nodrop", {7'd0, drop}, 8'h00);
        wait_grant(8'b0100_0000, 1'b1, "same_other");
        step(8'h00, 1'b1, "same_acc");
        wait_grant(8'b0010_0000, 1'b1, "same_again");
        step(8'h00, 1'b1, "same_acc2");

        // Reset mid-offer, asserted between edges
        do_reset();
        step(8'b0100_0000, 1'b0, "mid_req");
        step(8'h00, 1'b0, "mid_offer");
        chk("mid_offer_grant", grant, 8'b0100_0000);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_grant", grant, 8'h00);
        chk("mid_rst_valid", {7'd0, grant_valid}, 8'h00);
        chk("mid_rst_pending", pending, 8'h00);
        chk("mid_rst_drop", {7'd0, drop}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(8'b1111_1111, 1'b1, "mid_all");
        wait_grant(8'b0000_0001, 1'b1, "mid_first");

        // Fairness: all sources continuously re-requested rotate 0..7,0
        do_reset();
        ng = 0;
        for (int i = 0; i < 22; i++) begin
            if (grant_valid) begin
                chk("rotate", grant, 8'b0000_0001 << (ng % 8));
                ng++;
            end
            step(8'hFF, 1'b1, "rotate_step");
        end
        chk("rotate_count", 8'(ng), 8'd10);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) do_reset();
            r   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rdy, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
